// File: rtl/sa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_ctrl_pkg
// Description : Shared types for the SA_op run-time sequencer (state set and
//               array mode encodings).
// Revision    : 1.0 - initial release
// ============================================================================
package sa_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLR    = 4'd1,
    MACRST = 4'd2,
    FEED   = 4'd3,
    DRAIN  = 4'd4,
    OUT    = 4'd5,
    GAP    = 4'd6,
    FIN    = 4'd7,
    ABRT   = 4'd8
  } sa_state_e;

  localparam logic MODE_88 = 1'b0;
  localparam logic MODE_18 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sa_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sa_op_sequencer
// Description : Per-tile controller for SA_op: clear, MAC reset, operand
//               feed, drain and handshaked channel output pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_op_sequencer
  import sa_ctrl_pkg::*;
#(
  parameter int ROW_NUM     = 32,
  parameter int COLUMN_NUM  = 32,
  parameter int K_WIDTH     = 8,
  parameter int DRAIN_WIDTH = 7,
  parameter int OUTN_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_mode,
  input  logic [K_WIDTH-1:0]     cfg_k,
  input  logic [DRAIN_WIDTH-1:0] cfg_drain,
  input  logic [OUTN_WIDTH-1:0]  cfg_out_num,
  input  logic                   out_ready,
  output logic                   sa_reset,
  output logic                   sa_en,
  output logic                   sa_mode,
  output logic                   sa_channel_out_reset,
  output logic                   sa_channel_out_en,
  output logic                   feed_valid,
  output logic [K_WIDTH-1:0]     feed_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  localparam int c_cnt_w_kd = (K_WIDTH > DRAIN_WIDTH) ? K_WIDTH : DRAIN_WIDTH;
  localparam int c_cnt_w    = (c_cnt_w_kd > OUTN_WIDTH) ? c_cnt_w_kd : OUTN_WIDTH;

  if (DRAIN_WIDTH < $clog2(ROW_NUM + COLUMN_NUM + 1)) begin : g_drain_width_check
    $error("DRAIN_WIDTH too narrow for ROW_NUM+COLUMN_NUM");
  end

  sa_state_e              r_state, w_state_next;
  sa_state_e              w_post_drain_state, w_post_feed_state;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_next;
  logic [c_cnt_w-1:0]     w_k_load, w_drain_load, w_out_load, w_post_feed_cnt;
  logic [K_WIDTH-1:0]     r_k;
  logic [DRAIN_WIDTH-1:0] r_drain;
  logic [OUTN_WIDTH-1:0]  r_out_num;

  // Reload values are count-1 so each phase ends on the cycle the counter reads zero
  assign w_k_load     = c_cnt_w'(r_k) - c_cnt_w'(1);
  assign w_drain_load = c_cnt_w'(r_drain) - c_cnt_w'(1);
  assign w_out_load   = c_cnt_w'(r_out_num) - c_cnt_w'(1);

  assign w_post_drain_state = (r_out_num != '0) ? OUT : FIN;
  assign w_post_feed_state  = (r_drain != '0) ? DRAIN : w_post_drain_state;
  assign w_post_feed_cnt    = (r_drain != '0) ? w_drain_load : w_out_load;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE:   if (start) w_state_next = CLR;
      CLR:    w_state_next = MACRST;
      MACRST: begin
        if (r_k != '0) begin
          w_state_next = FEED;
          w_cnt_next   = w_k_load;
        end else begin
          w_state_next = w_post_feed_state;
          w_cnt_next   = w_post_feed_cnt;
        end
      end
      FEED: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - c_cnt_w'(1);
        end else begin
          w_state_next = w_post_feed_state;
          w_cnt_next   = w_post_feed_cnt;
        end
      end
      DRAIN: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - c_cnt_w'(1);
        end else begin
          w_state_next = w_post_drain_state;
          w_cnt_next   = w_out_load;
        end
      end
      OUT:    if (sa_channel_out_en) w_state_next = GAP;
      GAP: begin
        if (r_cnt != '0) begin
          w_state_next = OUT;
          w_cnt_next   = r_cnt - c_cnt_w'(1);
        end else begin
          w_state_next = FIN;
        end
      end
      FIN, ABRT: w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
    if (abort && (r_state != IDLE) && (r_state != ABRT)) w_state_next = ABRT;
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state              <= IDLE;
      r_cnt                <= '0;
      r_k                  <= '0;
      r_drain              <= '0;
      r_out_num            <= '0;
      sa_reset             <= 1'b1;
      sa_en                <= 1'b0;
      sa_mode              <= MODE_88;
      sa_channel_out_reset <= 1'b1;
      sa_channel_out_en    <= 1'b0;
      feed_valid           <= 1'b0;
      feed_idx             <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      aborted              <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if ((r_state == IDLE) && start) begin
        r_k       <= cfg_k;
        r_drain   <= cfg_drain;
        r_out_num <= cfg_out_num;
      end
      sa_reset             <= w_state_next inside {CLR, MACRST, ABRT};
      sa_en                <= w_state_next inside {FEED, DRAIN};
      sa_channel_out_reset <= w_state_next inside {CLR, FIN, ABRT};
      // out_ready is sampled on the edge that enters or holds OUT
      sa_channel_out_en    <= (w_state_next == OUT) && out_ready;
      feed_valid           <= (w_state_next == FEED);
      feed_idx             <= ((w_state_next == FEED) && (r_state == FEED)) ?
                              feed_idx + K_WIDTH'(1) : '0;
      busy                 <= (w_state_next != IDLE);
      done                 <= (w_state_next == FIN);
      aborted              <= (w_state_next == ABRT);
      sa_mode              <= (w_state_next == IDLE) ? MODE_88 :
                              (r_state == IDLE) ? cfg_mode : sa_mode;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sa_op_sequencer
// Description : Self-checking bench; expected per-cycle traces are built from
//               the tile schedule (phase lengths and out_ready pattern).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_op_sequencer;
  import sa_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_mode = 1'b0;
  logic [7:0] cfg_k = '0;
  logic [6:0] cfg_drain = '0;
  logic [2:0] cfg_out_num = '0;
  logic       out_ready = 1'b0;
  logic       sa_reset, sa_en, sa_mode, sa_channel_out_reset, sa_channel_out_en;
  logic       feed_valid, busy, done, aborted;
  logic [7:0] feed_idx;

  int checks = 0;
  int errors = 0;
  logic        rdy [0:1023];
  logic [16:0] exp_q[$];

  sa_op_sequencer #(
    .ROW_NUM(32), .COLUMN_NUM(32), .K_WIDTH(8), .DRAIN_WIDTH(7), .OUTN_WIDTH(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_k(cfg_k), .cfg_drain(cfg_drain),
    .cfg_out_num(cfg_out_num), .out_ready(out_ready),
    .sa_reset(sa_reset), .sa_en(sa_en), .sa_mode(sa_mode),
    .sa_channel_out_reset(sa_channel_out_reset),
    .sa_channel_out_en(sa_channel_out_en), .feed_valid(feed_valid),
    .feed_idx(feed_idx), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // {sa_reset, sa_en, sa_mode, ch_reset, ch_en, feed_valid, busy, done, aborted, feed_idx}
  function automatic logic [16:0] pack(bit rs, bit en, bit md, bit crs, bit cen,
                                       bit fv, bit bsy, bit dn, bit ab, logic [7:0] idx);
    return {rs, en, md, crs, cen, fv, bsy, dn, ab, idx};
  endfunction

  function automatic logic [16:0] observed();
    return {sa_reset, sa_en, sa_mode, sa_channel_out_reset, sa_channel_out_en,
            feed_valid, busy, done, aborted, feed_idx};
  endfunction

  // rdy_kind: 0 always ready, 1 random (never more than 4 low in a row), 2 low 4 cycles at first OUT
  task automatic run_tile(string name, bit mode, int k, int drain, int outn,
                          int rdy_kind, int abort_at, bit noisy);
    logic [16:0] exp_v;
    int n;
    for (int c = 0; c < 1024; c++) begin
      case (rdy_kind)
        0:       rdy[c] = 1'b1;
        1:       rdy[c] = (c % 5 == 4) ? 1'b1 : 1'($urandom_range(0, 1));
        default: rdy[c] = !(c >= 2 + k + drain && c <= 5 + k + drain);
      endcase
    end
    exp_q.delete();
    exp_q.push_back(pack(1, 0, mode, 1, 0, 0, 1, 0, 0, 8'd0));
    exp_q.push_back(pack(1, 0, mode, 0, 0, 0, 1, 0, 0, 8'd0));
    for (int i = 0; i < k; i++) exp_q.push_back(pack(0, 1, mode, 0, 0, 1, 1, 0, 0, 8'(i)));
    for (int i = 0; i < drain; i++) exp_q.push_back(pack(0, 1, mode, 0, 0, 0, 1, 0, 0, 8'd0));
    for (int p = 0; p < outn; p++) begin
      // a pulse lands in cycle c only if out_ready was high in cycle c-1
      while (!rdy[exp_q.size()]) exp_q.push_back(pack(0, 0, mode, 0, 0, 0, 1, 0, 0, 8'd0));
      exp_q.push_back(pack(0, 0, mode, 0, 1, 0, 1, 0, 0, 8'd0));
      exp_q.push_back(pack(0, 0, mode, 0, 0, 0, 1, 0, 0, 8'd0));
    end
    exp_q.push_back(pack(0, 0, mode, 1, 0, 0, 1, 1, 0, 8'd0));
    n = exp_q.size();
    if (abort_at < 0) abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
    if (abort_at > 0 && abort_at <= n) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(pack(1, 0, mode, 1, 0, 0, 1, 0, 1, 8'd0));
    end

    @(negedge clk);
    cfg_mode = mode; cfg_k = 8'(k); cfg_drain = 7'(drain); cfg_out_num = 3'(outn);
    start = 1'b1; abort = 1'b0; out_ready = rdy[0];
    for (int c = 1; c <= exp_q.size() + 1; c++) begin
      @(negedge clk);
      exp_v = (c <= exp_q.size()) ? exp_q[c-1] : 17'd0;
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, observed(), exp_v);
      end
      start = (noisy && c <= exp_q.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) begin
        cfg_mode = 1'($urandom); cfg_k = 8'($urandom); cfg_drain = 7'($urandom);
        cfg_out_num = 3'($urandom);
      end
      out_ready = rdy[c];
      abort = (c == abort_at);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (observed() !== pack(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'd0)) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", observed(),
               pack(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'd0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (observed() !== 17'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", observed(), 17'd0);
    end
  endtask

  task automatic test_basic_8x8();      run_tile("basic_8x8", 0, 2, 3, 2, 0, 0, 0); endtask
  task automatic test_mode_1x8();       run_tile("mode_1x8", MODE_18, 2, 2, 1, 0, 0, 0); endtask
  task automatic test_out_backpressure(); run_tile("backpressure", 0, 3, 2, 3, 2, 0, 0); endtask
  task automatic test_abort_feed();     run_tile("abort_feed", 1, 4, 3, 2, 0, 4, 0); endtask
  task automatic test_zero_lengths();   run_tile("zero_lengths", 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic test_back_to_back();
    run_tile("b2b_a", 1, 1, 0, 1, 0, 0, 1);
    run_tile("b2b_b", 0, 0, 1, 2, 0, 0, 1);
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    cfg_mode = 1; cfg_k = 8'd2; cfg_drain = 7'd5; cfg_out_num = 3'd2;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sa_en !== 1'b1 || feed_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drain_pre: got sa_en=%b feed_valid=%b expected 1 0", sa_en, feed_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (observed() !== pack(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'd0)) begin
      errors++;
      $display("FAIL reset_mid_drain_async: got %h expected %h", observed(),
               pack(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'd0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== 17'd0) begin
        errors++;
        $display("FAIL reset_mid_drain_idle[%0d]: got %h expected %h", i, observed(), 17'd0);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++)
      run_tile("random", 1'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
               int'($urandom_range(0, 7)), 1, -1, 1);
  endtask

  initial begin
    test_reset();
    test_basic_8x8();
    test_mode_1x8();
    test_out_backpressure();
    test_abort_feed();
    test_zero_lengths();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
